jtag_tap_sampled: RTL and testbench
===================================

Name: jtag_tap_sampled

Overview:
Synchronous JTAG TAP responder. It is the device end of the JTAG link driven by the SimJTAG/OpenOCD bridge. TCK/TMS/TDI/TRSTn are oversampled in the clk_i domain, so no TCK clock domain exists, and the block implements the IEEE 1149.1 16-state TAP FSM. It provides IDCODE, BYPASS and a 32-bit USER data register with a parallel capture/update handshake into SoC logic. It is used in sim and as a lightweight debug tap on FPGA builds.

Parameters:
IDCODE, 32'h1BEE_F001, value returned by the IDCODE instruction; bit 0 must be 1.
SYNC_STAGES, 2, synchronizer depth on tck_i/tms_i/tdi_i/trst_ni; legal range 2..4.
USER_IR, 5'h10, instruction code that selects the USER register.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  synchronous reset, active-high.
tck_i  in  1  JTAG TCK, asynchronous to clk_i.
tms_i  in  1  JTAG TMS.
tdi_i  in  1  JTAG TDI.
trst_ni  in  1  JTAG TRST, active-low; synchronized, treated as a level.
tdo_o  out  1  JTAG TDO.
tdo_oe_o  out  1  TDO driven; high only in Shift-IR and Shift-DR.
user_capture_data_i  in  32  value loaded into USER DR at Capture-DR.
user_update_o  out  1  one-clk_i pulse at Update-DR while IR==USER_IR.
user_update_data_o  out  32  USER DR contents latched at Update-DR; held until the next update.
tap_state_o  out  4  current TAP state (debug).

Behaviour:
- Sampling: all four JTAG inputs pass through SYNC_STAGES flops, plus one history flop on TCK.
  - tck_rise = sync & ~hist; tck_fall = ~sync & hist.
  - Edge detection latency is SYNC_STAGES+1 clk_i cycles after the pin edge.
  - TCK high and low phases must each last at least SYNC_STAGES+2 clk_i cycles. Shorter phases are unsupported and cause no required behaviour.
- State encoding, with Exit1 branches on tms=1 (standard codes):
  - Exit2-DR 0, Exit1-DR 1, Shift-DR 2, Pause-DR 3.
  - Select-IR 4, Update-DR 5, Capture-DR 6, Select-DR 7.
  - Exit2-IR 8, Exit1-IR 9, Shift-IR A, Pause-IR B.
  - RTI C, Update-IR D, Capture-IR E, TLR F.
  - Transitions follow the standard 1149.1 table, evaluated only on tck_rise using synchronized TMS.
- Actions on tck_rise are keyed on the state before the transition:
  - Capture-IR: ir_shift <= 5'b00001.
  - Shift-IR: ir_shift <= {tdi, ir_shift[4:1]}.
  - Update-IR: ir <= ir_shift.
  - Capture-DR: load the selected DR:
    - IDCODE (ir==5'h01) loads the IDCODE parameter.
    - USER_IR loads user_capture_data_i.
    - Any other ir, including 5'h1F, selects BYPASS, which captures 0.
  - Shift-DR: for 32-bit DRs, dr <= {tdi, dr[31:1]}; for BYPASS, byp <= tdi.
  - Update-DR with ir==USER_IR: user_update_data_o <= dr; user_update_o = 1 for exactly the next clk_i cycle.
  - TLR, entered or held: ir <= 5'h01 (IDCODE).
- TDO on tck_fall:
  - In Shift-IR: tdo_o <= ir_shift[0].
  - In Shift-DR: tdo_o <= dr[0], or byp for BYPASS.
  - tdo_oe_o <= 1 in either shift state.
  - In all other states: tdo_oe_o <= 0 and tdo_o <= 0.
- Five consecutive tck_rise with tms=1 reach TLR from any state.
- trst_ni synchronized low: the state is forced to TLR and ir to 5'h01 every cycle, overriding TCK activity. This has no effect on user_update_data_o.
- rst_i (synchronous, highest priority) sets:
  - state to TLR, ir to 5'h01, ir_shift and dr to 0, byp to 0;
  - tdo_o 0, tdo_oe_o 0, user_update_o 0, user_update_data_o 0, tap_state_o 4'hF;
  - synchronizer and history flops to 0.
- rst_i asserted mid-shift aborts the shift: the partial DR is discarded and no update pulse is generated.
- A tck_rise and a tck_fall can never occur in the same clk_i cycle, given the phase constraint.
- user_capture_data_i is sampled only on the Capture-DR tck_rise cycle. Its value at any other time has no effect.

Test Plan:
- Release rst_i, then drive TMS=1 for 5 TCKs from an arbitrary state -> tap_state_o==4'hF and ir==5'h01.
- From TLR, drive TMS 0,1,0,0 then shift 32 TCKs -> tdo_o bits LSB-first equal 32'h1BEE_F001, and tdo_oe_o==1 only during Shift-DR.
- Scan IR=5'h10 (the first 5 TDO bits read 1,0,0,0,0), set user_capture_data_i=32'hDEAD_BEEF, shift in 32'hA5A5_1234 -> tdo_o reads 32'hDEAD_BEEF. At Update-DR, user_update_o pulses for 1 cycle and user_update_data_o==32'hA5A5_1234.
- Scan IR=5'h1F, shift pattern 1,0,1,1 through DR -> TDO shows 0 followed by 1,0,1, i.e. one TCK of delay.
- Assert rst_i after 16 of 32 USER shift bits -> all outputs at reset values, no user_update_o, user_update_data_o==0.
- Pulse trst_ni low for 10 clk_i during Shift-DR -> tap_state_o==4'hF, ir==5'h01, and user_update_data_o keeps its prior value.

Source files
------------

// File: rtl/jtag_tap_sampled.sv
// JTAG TAP responder with TCK/TMS/TDI/TRSTn oversampled in clk_i (no TCK clock domain).
// Provides IDCODE, BYPASS and a 32-bit USER data register with a parallel capture/update port.
module jtag_tap_sampled #(
    parameter logic [31:0] IDCODE      = 32'h1BEE_F001,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [4:0]  USER_IR     = 5'h10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tck_i,
    input  logic        tms_i,
    input  logic        tdi_i,
    input  logic        trst_ni,
    output logic        tdo_o,
    output logic        tdo_oe_o,
    input  logic [31:0] user_capture_data_i,
    output logic        user_update_o,
    output logic [31:0] user_update_data_o,
    output logic [3:0]  tap_state_o
);
    localparam logic [4:0] IR_IDCODE = 5'h01;

    typedef enum logic [3:0] {
        EXIT2_DR  = 4'h0, EXIT1_DR   = 4'h1, SHIFT_DR   = 4'h2, PAUSE_DR   = 4'h3,
        SELECT_IR = 4'h4, UPDATE_DR  = 4'h5, CAPTURE_DR = 4'h6, SELECT_DR  = 4'h7,
        EXIT2_IR  = 4'h8, EXIT1_IR   = 4'h9, SHIFT_IR   = 4'hA, PAUSE_IR   = 4'hB,
        RUN_IDLE  = 4'hC, UPDATE_IR  = 4'hD, CAPTURE_IR = 4'hE, TEST_RESET = 4'hF
    } tap_state_e;

    // Each synchronizer stage holds {trst_n, tdi, tms, tck}
    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic        tck_hist_q, tck_hist_d;
    logic        tck_s, tms_s, tdi_s, trst_s_n, tck_rise, tck_fall;
    tap_state_e  state_q, state_d, state_nxt;
    logic [4:0]  ir_q, ir_d, ir_shift_q, ir_shift_d;
    logic [31:0] dr_q, dr_d, upd_data_q, upd_data_d;
    logic        byp_q, byp_d, tdo_q, tdo_d, tdo_oe_q, tdo_oe_d, upd_q, upd_d;
    logic        sel_idcode, sel_user, sel_bypass;

    assign tck_s    = sync_q[SYNC_STAGES-1][0];
    assign tms_s    = sync_q[SYNC_STAGES-1][1];
    assign tdi_s    = sync_q[SYNC_STAGES-1][2];
    assign trst_s_n = sync_q[SYNC_STAGES-1][3];
    assign tck_rise = tck_s & ~tck_hist_q;
    assign tck_fall = ~tck_s & tck_hist_q;

    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_user   = (ir_q == USER_IR) && !sel_idcode;
    assign sel_bypass = !sel_idcode && !sel_user;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], trst_ni, tdi_i, tms_i, tck_i};
        tck_hist_d = tck_s;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            TEST_RESET: state_nxt = tms_s ? TEST_RESET : RUN_IDLE;
            RUN_IDLE:   state_nxt = tms_s ? SELECT_DR  : RUN_IDLE;
            SELECT_DR:  state_nxt = tms_s ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR: state_nxt = tms_s ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:   state_nxt = tms_s ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:   state_nxt = tms_s ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:   state_nxt = tms_s ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:   state_nxt = tms_s ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:  state_nxt = tms_s ? SELECT_DR  : RUN_IDLE;
            SELECT_IR:  state_nxt = tms_s ? TEST_RESET : CAPTURE_IR;
            CAPTURE_IR: state_nxt = tms_s ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:   state_nxt = tms_s ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:   state_nxt = tms_s ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:   state_nxt = tms_s ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:   state_nxt = tms_s ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:  state_nxt = tms_s ? SELECT_DR  : RUN_IDLE;
            default:    state_nxt = TEST_RESET;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        dr_d       = dr_q;
        byp_d      = byp_q;
        tdo_d      = tdo_q;
        tdo_oe_d   = tdo_oe_q;
        upd_d      = 1'b0;
        upd_data_d = upd_data_q;

        // Register actions belong to the state being left on this TCK rise
        if (tck_rise) begin
            state_d = state_nxt;
            case (state_q)
                CAPTURE_IR: ir_shift_d = 5'b00001;
                SHIFT_IR:   ir_shift_d = {tdi_s, ir_shift_q[4:1]};
                UPDATE_IR:  ir_d = ir_shift_q;
                CAPTURE_DR: begin
                    if (sel_idcode)    dr_d  = IDCODE;
                    else if (sel_user) dr_d  = user_capture_data_i;
                    else               byp_d = 1'b0;
                end
                SHIFT_DR: begin
                    if (sel_bypass) byp_d = tdi_s;
                    else            dr_d  = {tdi_s, dr_q[31:1]};
                end
                UPDATE_DR: begin
                    if (sel_user) begin
                        upd_data_d = dr_q;
                        upd_d      = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (tck_fall) begin
            tdo_d    = 1'b0;
            tdo_oe_d = 1'b0;
            if (state_q == SHIFT_IR) begin
                tdo_d    = ir_shift_q[0];
                tdo_oe_d = 1'b1;
            end else if (state_q == SHIFT_DR) begin
                tdo_d    = sel_bypass ? byp_q : dr_q[0];
                tdo_oe_d = 1'b1;
            end
        end

        if (state_d == TEST_RESET) ir_d = IR_IDCODE;

        if (!trst_s_n) begin
            state_d = TEST_RESET;
            ir_d    = IR_IDCODE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q     <= '0;
            tck_hist_q <= 1'b0;
            state_q    <= TEST_RESET;
            ir_q       <= IR_IDCODE;
            ir_shift_q <= '0;
            dr_q       <= '0;
            byp_q      <= 1'b0;
            tdo_q      <= 1'b0;
            tdo_oe_q   <= 1'b0;
            upd_q      <= 1'b0;
            upd_data_q <= '0;
        end else begin
            sync_q     <= sync_d;
            tck_hist_q <= tck_hist_d;
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            dr_q       <= dr_d;
            byp_q      <= byp_d;
            tdo_q      <= tdo_d;
            tdo_oe_q   <= tdo_oe_d;
            upd_q      <= upd_d;
            upd_data_q <= upd_data_d;
        end
    end

    assign tdo_o              = tdo_q;
    assign tdo_oe_o           = tdo_oe_q;
    assign user_update_o      = upd_q;
    assign user_update_data_o = upd_data_q;
    assign tap_state_o        = state_q;
endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Bench for jtag_tap_sampled: TCK-level behavioural TAP model checked every settled clk_i cycle,
// plus literal expectations for IDCODE, USER capture/update, BYPASS delay, rst_i and TRST.
module tb_jtag_tap_sampled;
    localparam int          SS  = 2;
    localparam int          PH  = 6;
    localparam logic [31:0] IDC = 32'h1BEE_F001;
    localparam logic [4:0]  UIR = 5'h10;

    logic        clk_i = 1'b0, rst_i = 1'b1, tck_i = 1'b0, tms_i = 1'b0, tdi_i = 1'b0, trst_ni = 1'b1;
    logic        tdo_o, tdo_oe_o, user_update_o;
    logic [31:0] user_capture_data_i = 32'h0;
    logic [31:0] user_update_data_o;
    logic [3:0]  tap_state_o;

    jtag_tap_sampled #(.IDCODE(IDC), .SYNC_STAGES(SS), .USER_IR(UIR)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
        .trst_ni(trst_ni), .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o),
        .user_capture_data_i(user_capture_data_i), .user_update_o(user_update_o),
        .user_update_data_o(user_update_data_o), .tap_state_o(tap_state_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0, since = 0, dut_upd = 0, m_upd = 0;

    // 1149.1 successor tables indexed by state code, for TMS=0 and TMS=1
    logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                              4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                              4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    logic [3:0]  m_state;
    logic [4:0]  m_ir, m_irsh;
    logic [31:0] m_dr, m_upd_data;
    logic        m_byp, m_tdo, m_oe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_is_bypass();
        return !(m_ir == 5'h01 || m_ir == UIR);
    endfunction

    task automatic m_reset();
        m_state = 4'hF; m_ir = 5'h01; m_irsh = '0; m_dr = '0; m_byp = 1'b0;
        m_tdo = 1'b0; m_oe = 1'b0; m_upd_data = '0;
    endtask

    task automatic m_rise(input logic tms, input logic tdi);
        logic [3:0] s;
        s = m_state;
        if (s == 4'hE) m_irsh = 5'b00001;
        else if (s == 4'hA) m_irsh = {tdi, m_irsh[4:1]};
        else if (s == 4'hD) m_ir = m_irsh;
        else if (s == 4'h6) begin
            if (m_ir == 5'h01) m_dr = IDC;
            else if (m_ir == UIR) m_dr = user_capture_data_i;
            else m_byp = 1'b0;
        end else if (s == 4'h2) begin
            if (m_is_bypass()) m_byp = tdi;
            else m_dr = {tdi, m_dr[31:1]};
        end else if (s == 4'h5 && m_ir == UIR) begin
            m_upd_data = m_dr;
            m_upd++;
        end
        m_state = tms ? nxt1[s] : nxt0[s];
        if (m_state == 4'hF) m_ir = 5'h01;
    endtask

    task automatic m_fall();
        m_tdo = 1'b0; m_oe = 1'b0;
        if (m_state == 4'hA) begin m_tdo = m_irsh[0]; m_oe = 1'b1; end
        else if (m_state == 4'h2) begin m_tdo = m_is_bypass() ? m_byp : m_dr[0]; m_oe = 1'b1; end
    endtask

    // One clk_i cycle; outputs compared to the model once the pins have had time to propagate
    task automatic tick();
        @(negedge clk_i);
        if (user_update_o === 1'b1) dut_upd++;
        since++;
        if (since >= SS + 2) begin
            chk("tap_state", 32'(tap_state_o), 32'(m_state));
            chk("tdo", 32'(tdo_o), 32'(m_tdo));
            chk("tdo_oe", 32'(tdo_oe_o), 32'(m_oe));
            chk("upd_data", user_update_data_o, m_upd_data);
            chk("upd_pulses", 32'(dut_upd), 32'(m_upd));
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic tck_cycle(input logic tms, input logic tdi);
        tms_i = tms; tdi_i = tdi;
        repeat (2) tick();
        tck_i = 1'b1; since = 0; m_rise(tms, tdi);
        repeat (PH) tick();
        tck_i = 1'b0; since = 0; m_fall();
        repeat (PH) tick();
    endtask

    task automatic to_tlr();
        repeat (5) tck_cycle(1'b1, 1'($urandom_range(0, 1)));
    endtask

    // Assumes a shift state with the first bit already on TDO; records TDO LSB-first
    task automatic shift(input logic [31:0] din, input int n, input logic last_tms,
                         output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo_o;
            tck_cycle((i == n - 1) ? last_tms : 1'b0, din[i]);
        end
    endtask

    task automatic scan_ir(input logic [4:0] v, output logic [4:0] cap);
        logic [31:0] d;
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
        shift({27'h0, v}, 5, 1'b1, d);
        cap = d[4:0];
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0);
    endtask

    task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
        chk("oe_in_shift_dr", 32'(tdo_oe_o), 32'd1);
        shift(din, n, 1'b1, dout);
        chk("oe_after_shift_dr", 32'(tdo_oe_o), 32'd0);
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0);
    endtask

    task automatic trst_pulse(input int n);
        trst_ni = 1'b0; since = 0; m_state = 4'hF; m_ir = 5'h01;
        repeat (n) tick();
        trst_ni = 1'b1; since = 0;
        repeat (4) tick();
    endtask

    initial begin
        logic [31:0] dout, v1;
        logic [4:0]  irc;
        int          upd0;
        m_reset();
        @(posedge clk_i); #1;
        since = 0;
        repeat (6) tick();
        chk("rst_state", 32'(tap_state_o), 32'hF);
        chk("rst_tdo_oe", 32'(tdo_oe_o), 32'd0);
        chk("rst_upd_data", user_update_data_o, 32'h0);
        rst_i = 1'b0; since = 0;
        repeat (4) tick();

        repeat (17) tck_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        to_tlr();
        chk("tlr_after_5_tms", 32'(tap_state_o), 32'hF);

        tck_cycle(1'b0, 1'b0);
        scan_dr(32'($urandom), 32, dout);
        chk("idcode_read", dout, IDC);

        scan_ir(UIR, irc);
        chk("ir_capture", 32'(irc), 32'h01);
        user_capture_data_i = 32'hDEAD_BEEF;
        upd0 = dut_upd;
        scan_dr(32'hA5A5_1234, 32, dout);
        chk("user_capture", dout, 32'hDEAD_BEEF);
        chk("user_update_data", user_update_data_o, 32'hA5A5_1234);
        chk("user_update_once", 32'(dut_upd - upd0), 32'd1);

        scan_ir(5'h1F, irc);
        upd0 = dut_upd;
        scan_dr(32'h0000_000D, 4, dout);
        chk("bypass_delay", dout, 32'h0000_000A);
        chk("bypass_no_update", 32'(dut_upd - upd0), 32'd0);

        scan_ir(UIR, irc);
        user_capture_data_i = 32'($urandom);
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
        shift(32'($urandom), 16, 1'b0, dout);
        upd0 = dut_upd;
        rst_i = 1'b1; since = 0; m_reset();
        repeat (5) tick();
        rst_i = 1'b0; since = 0;
        repeat (4) tick();
        chk("midshift_rst_state", 32'(tap_state_o), 32'hF);
        chk("midshift_rst_data", user_update_data_o, 32'h0);
        chk("midshift_rst_tdo", 32'(tdo_o), 32'd0);
        chk("midshift_rst_no_pulse", 32'(dut_upd - upd0), 32'd0);

        tck_cycle(1'b0, 1'b0);
        scan_ir(UIR, irc);
        v1 = 32'($urandom);
        scan_dr(v1, 32, dout);
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
        shift(32'($urandom), 10, 1'b0, dout);
        trst_pulse(10);
        chk("trst_state", 32'(tap_state_o), 32'hF);
        chk("trst_keeps_data", user_update_data_o, v1);
        tck_cycle(1'b0, 1'b0);
        scan_dr(32'($urandom), 32, dout);
        chk("trst_ir_idcode", dout, IDC);

        for (int blk = 0; blk < 4; blk++) begin
            to_tlr();
            tck_cycle(1'b0, 1'b0);
            scan_ir((blk % 2 == 0) ? UIR : 5'($urandom), irc);
            for (int k = 0; k < 80; k++) begin
                if ($urandom_range(0, 49) == 0) trst_pulse(int'($urandom_range(4, 12)));
                else begin
                    if ($urandom_range(0, 3) == 0) user_capture_data_i = 32'($urandom);
                    tck_cycle($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
